// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 width codes and FSM state encodings shared by the load/store unit.
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/lsu_load_store_load_extend.sv
// load_extend: shifts the selected byte/halfword of a bus word down and sign- or zero-extends it.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] bus_rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);
  logic [31:0] sh;
  always_comb begin
    sh = bus_rdata >> {offset, 3'b000};
    data = funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
           funct3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
           funct3 == F3_BU ? {24'b0, sh[7:0]} :
           funct3 == F3_HU ? {16'b0, sh[15:0]} : sh;
  end
endmodule

// File: rtl/lsu_load_store.sv
// lsu_load_store: turns core load/store requests into one word-aligned byte-enabled bus access with timeout.
module lsu_load_store
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] data_out,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [1:0] off;
  logic [2:0] f3;
  logic legal, aligned, accept, reject, timeout;
  logic [3:0] be_nx;
  logic [31:0] wdata_nx, ext;
  load_extend u_ext (.bus_rdata(bus_rdata), .offset(off), .funct3(f3), .data(ext));
  always_comb begin
    legal = mem_wr ? (funct3 inside {F3_B, F3_H, F3_W})
                   : (funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    aligned = funct3[1:0] == 2'b01 ? ~addr[0] :
              funct3[1:0] == 2'b10 ? addr[1:0] == 2'b00 : 1'b1;
    accept = state == S_IDLE && (mem_rd || mem_wr) && legal && aligned;
    reject = state == S_IDLE && (mem_rd || mem_wr) && !(legal && aligned);
    timeout = state == S_WAIT && !bus_ready && cnt == CNT_W'(TIMEOUT - 1);
    state_nx = state == S_IDLE ? (accept ? S_WAIT : S_IDLE) :
               state == S_WAIT ? ((bus_ready || timeout) ? S_DONE : S_WAIT) : S_IDLE;
    stall = rst_n && (accept || state == S_WAIT);
    bus_req = state == S_WAIT;
    be_nx = funct3[1:0] == 2'b00 ? 4'b0001 << addr[1:0] :
            funct3[1:0] == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_nx = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
               funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      off <= '0;
      f3 <= '0;
      data_out <= '0;
      bus_addr <= '0;
      bus_be <= '0;
      bus_wdata <= '0;
      bus_we <= 1'b0;
      misaligned <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      state <= state_nx;
      misaligned <= reject;
      bus_err <= timeout;
      if (accept) begin
        bus_addr <= {addr[31:2], 2'b00};
        bus_be <= be_nx;
        bus_wdata <= wdata_nx;
        bus_we <= mem_wr;
        off <= addr[1:0];
        f3 <= funct3;
        cnt <= '0;
      end else if (state == S_WAIT) cnt <= cnt + 1'b1;
      // a timed-out load returns zero; stores never touch data_out
      if (state == S_WAIT && !bus_we && (bus_ready || timeout))
        data_out <= bus_ready ? ext : '0;
    end
  end
endmodule

// File: tb/tb_lsu_load_store.sv
// tb_lsu_load_store: directed and random load/store accesses checked against a spec-level model.
module tb_lsu_load_store;
  localparam int TO = 4;
  logic clk = 0, rst_n = 0, mem_rd = 0, mem_wr = 0, bus_ready = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] addr = 0, wdata = 0, bus_rdata = 0;
  logic [31:0] data_out, bus_addr, bus_wdata;
  logic [3:0] bus_be;
  logic stall, misaligned, bus_err, bus_req, bus_we;
  int tests = 0, fails = 0;
  logic [31:0] exp_dout = 0;
  always #5 clk = ~clk;
  lsu_load_store #(.TIMEOUT(TO), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd), .mem_wr(mem_wr), .funct3(funct3),
    .addr(addr), .wdata(wdata), .data_out(data_out), .stall(stall),
    .misaligned(misaligned), .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic int size_of(input logic [2:0] f3);
    return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
  endfunction
  function automatic logic [31:0] load_model(input logic [31:0] rd, input int off, input logic [2:0] f3);
    logic [31:0] w;
    w = rd >> (8 * off);
    case (f3)
      3'd0: return (w % 256) >= 128 ? (w % 256) - 256 : w % 256;
      3'd1: return (w % 65536) >= 32768 ? (w % 65536) - 65536 : w % 65536;
      3'd4: return w % 256;
      3'd5: return w % 65536;
      default: return w;
    endcase
  endfunction
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdat, input int delay);
    bit legal, to;
    int sz, off;
    logic [3:0] ebe;
    logic [31:0] ewd;
    sz = size_of(f3);
    off = int'(a[1:0]);
    legal = (wr ? f3 inside {0, 1, 2} : f3 inside {0, 1, 2, 4, 5}) && (off % sz) == 0;
    for (int i = 0; i < 4; i++) begin
      ebe[i] = i >= off && i < off + sz;
      ewd[8*i +: 8] = wd[8*(i % sz) +: 8];
    end
    @(negedge clk);
    mem_rd = rd; mem_wr = wr; funct3 = f3; addr = a; wdata = wd;
    bus_ready = 1'($urandom);
    #1 chk("accept_stall", 32'(stall), 32'(legal));
    if (!legal) begin
      @(negedge clk);
      chk("mis_pulse", 32'(misaligned), 1);
      chk("mis_no_req", 32'(bus_req), 0);
      chk("mis_stall", 32'(stall), 0);
      chk("mis_dout", data_out, exp_dout);
      mem_rd = 0; mem_wr = 0; bus_ready = 0;
      @(negedge clk);
      chk("mis_end", 32'(misaligned), 0);
      chk("mis_no_req2", 32'(bus_req), 0);
      return;
    end
    bus_ready = 0;
    for (int n = 0; n < TO; n++) begin
      @(negedge clk);
      chk("wait_req", 32'(bus_req), 1);
      chk("wait_stall", 32'(stall), 1);
      if (n == 0) begin
        chk("bus_addr", bus_addr, {a[31:2], 2'b00});
        chk("bus_be", 32'(bus_be), 32'(ebe));
        chk("bus_we", 32'(bus_we), 32'(wr));
        if (wr) chk("bus_wdata", bus_wdata, ewd);
      end
      if (n == delay) begin
        bus_ready = 1; bus_rdata = rdat;
        break;
      end
      bus_rdata = $urandom;
    end
    to = delay >= TO;
    @(negedge clk);
    bus_ready = 0;
    if (!wr) exp_dout = to ? 32'h0 : load_model(rdat, off, f3);
    chk("done_req", 32'(bus_req), 0);
    chk("done_stall", 32'(stall), 0);
    chk("done_err", 32'(bus_err), 32'(to));
    chk("done_dout", data_out, exp_dout);
    mem_rd = 0; mem_wr = 0;
    @(negedge clk);
    chk("idle_req", 32'(bus_req), 0);
    chk("idle_err", 32'(bus_err), 0);
    chk("idle_dout", data_out, exp_dout);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_req", 32'(bus_req), 0);
    chk("rst_dout", data_out, 0);
    chk("rst_be", 32'(bus_be), 0);
    chk("rst_err", 32'(bus_err | misaligned), 0);
    rst_n = 1;
    access(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 2);
    access(1, 0, 3'b000, 32'h103, 0, 32'h80112233, 0);
    access(1, 0, 3'b100, 32'h103, 0, 32'h80112233, 1);
    access(1, 0, 3'b101, 32'h102, 0, 32'h80112233, 3);
    access(0, 1, 3'b000, 32'h201, 32'h000000A5, 0, 1);
    access(0, 1, 3'b001, 32'h202, 32'h1234BEEF, 0, 0);
    access(1, 1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h11111111, 2);
    access(1, 0, 3'b010, 32'h102, 0, 0, 0);
    access(1, 0, 3'b011, 32'h100, 0, 0, 0);
    access(0, 1, 3'b100, 32'h100, 0, 0, 0);
    access(1, 0, 3'b010, 32'h104, 0, 32'h55AA55AA, TO);
    access(1, 0, 3'b001, 32'h106, 0, 32'hF00DCAFE, TO - 1);
    // reset in the middle of a load
    @(negedge clk);
    mem_rd = 1; funct3 = 3'b010; addr = 32'h400;
    @(negedge clk);
    chk("pre_rst_req", 32'(bus_req), 1);
    rst_n = 0;
    #1 chk("rst_force_stall", 32'(stall), 0);
    @(negedge clk);
    chk("post_rst_req", 32'(bus_req), 0);
    chk("post_rst_dout", data_out, 0);
    exp_dout = 0;
    mem_rd = 0; rst_n = 1;
    access(1, 0, 3'b010, 32'h400, 0, 32'h0BADF00D, 1);
    for (int k = 0; k < 60; k++) begin
      logic w;
      w = 1'($urandom);
      access(~w | 1'($urandom), w, 3'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, TO));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
